// File: rtl/uart_tx.sv
// uart_tx: serializes a parallel word into a UART frame, one bit per clk.
// Frame layout on tx_out: start (0), data LSB first, optional parity, stop (1).
// The line idles high. tx_out and busy come straight from flops.
//
// Handshake: data_valid is the request and ~busy is the ready. A word is
// accepted at a rising edge where data_valid=1 and the FSM is in IDLE.
// p_data, par_en and par_type are sampled only at that edge. The upstream
// side must hold data_valid until busy rises, or pulse it only while busy=0.
// No request is queued while a frame is in flight.
module uart_tx #(
   parameter int dataWidth = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [dataWidth-1:0] p_data,
   input  logic                 data_valid,
   input  logic                 par_en,
   input  logic                 par_type,
   output logic                 tx_out,
   output logic                 busy,
   output logic [2:0]           state_dbg
);

   localparam int CNT_W = (dataWidth > 1) ? $clog2(dataWidth) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(dataWidth - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     bit_cnt;
   logic [CNT_W-1:0]     next_cnt;
   logic [dataWidth-1:0] data_reg;
   logic                 par_en_reg;
   logic                 par_type_reg;
   logic                 parity_bit;

   // Raw FSM state, exported so external checkers can follow the frame.
   assign state_dbg = state;

   // Next bit index, and the parity of the latched word (even when par_type=0).
   always_comb begin
      next_cnt   = bit_cnt + CNT_W'(1);
      parity_bit = par_type_reg ? ~(^data_reg) : (^data_reg);
   end

   // Frame sequencer. Outputs are loaded with the value for the state being
   // entered, so the line level always matches the current state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         data_reg     <= '0;
         par_en_reg   <= 1'b0;
         par_type_reg <= 1'b0;
         tx_out       <= 1'b1;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tx_out  <= 1'b1;
               busy    <= 1'b0;
               bit_cnt <= '0;
               if (data_valid) begin
                  data_reg     <= p_data;
                  par_en_reg   <= par_en;
                  par_type_reg <= par_type;
                  state        <= START;
                  tx_out       <= 1'b0;
                  busy         <= 1'b1;
               end
            end
            START: begin
               // Start bit is on the line now; present data bit 0 next.
               state   <= DATA;
               bit_cnt <= '0;
               tx_out  <= data_reg[0];
            end
            DATA: begin
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt <= '0;
                  if (par_en_reg) begin
                     state  <= PARITY;
                     tx_out <= parity_bit;
                  end else begin
                     state  <= STOP;
                     tx_out <= 1'b1;
                  end
               end else begin
                  bit_cnt <= next_cnt;
                  tx_out  <= data_reg[next_cnt];
               end
            end
            PARITY: begin
               state  <= STOP;
               tx_out <= 1'b1;
            end
            STOP: begin
               // Stop bit ends. The line stays high, and busy drops as IDLE begins.
               state  <= IDLE;
               tx_out <= 1'b1;
               busy   <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               tx_out <= 1'b1;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule
